// File: rtl/sigan_multi.sv
// Multi-channel signature analyser: each channel folds its probe data into a
// per-channel LFSR signature over a window bounded by probe start/stop edges.
module sigan_multi #(
  parameter int               CHANNELS = 8,
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = 16'h8940,
  parameter int               COUNT_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      continuous,
  input  logic                      clk_pol,
  input  logic                      start_pol,
  input  logic                      stop_pol,
  input  logic                      probe_clk,
  input  logic                      probe_start,
  input  logic                      probe_stop,
  input  logic [CHANNELS-1:0]       probe_data,
  output logic [CHANNELS*WIDTH-1:0] signature,
  output logic                      sig_valid,
  output logic                      sig_stable,
  output logic                      gate_open,
  output logic                      busy,
  output logic [COUNT_W-1:0]        count,
  output logic                      count_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    GATE  = 2'd2
  } state_t;

  state_t                    state;
  logic                      clk_q;
  logic                      start_hist;
  logic                      stop_hist;
  logic [CHANNELS*WIDTH-1:0] sr;
  logic [CHANNELS*WIDTH-1:0] cap_sig;
  logic [COUNT_W-1:0]        win_cnt;
  logic [COUNT_W-1:0]        cap_cnt;
  logic                      cap_ovf;
  logic                      cap_pend;
  logic                      have_prior;
  logic                      probe_edge;
  logic                      start_event;
  logic                      stop_event;

  function automatic logic [CHANNELS*WIDTH-1:0] load_all(input logic [CHANNELS-1:0] d);
    logic [CHANNELS*WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      v[i*WIDTH] = d[i];
    end
    return v;
  endfunction

  function automatic logic [CHANNELS*WIDTH-1:0] shift_all(input logic [CHANNELS*WIDTH-1:0] cur,
                                                          input logic [CHANNELS-1:0]       d);
    logic [CHANNELS*WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      v[i*WIDTH +: WIDTH] = {cur[i*WIDTH +: WIDTH-1], d[i] ^ (^(cur[i*WIDTH +: WIDTH] & TAPS))};
    end
    return v;
  endfunction

  // Start/stop are levels sampled only at active probe edges; an event is the
  // first sample at the active level after a sample that was not.
  assign probe_edge  = (probe_clk != clk_q) && (probe_clk == clk_pol);
  assign start_event = probe_edge && (probe_start == start_pol) && (start_hist != start_pol);
  assign stop_event  = probe_edge && (probe_stop == stop_pol) && (stop_hist != stop_pol);

  // Probe clock history and per-edge start/stop samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_q      <= 1'b0;
      start_hist <= 1'b0;
      stop_hist  <= 1'b0;
    end else begin
      clk_q <= probe_clk;
      if (probe_edge) begin
        start_hist <= probe_start;
        stop_hist  <= probe_stop;
      end
    end
  end

  // Window FSM and per-channel shift registers; a stop parks the result in the
  // capture stage so a coincident start can reload the registers at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      win_cnt   <= '0;
      cap_sig   <= '0;
      cap_cnt   <= '0;
      cap_ovf   <= 1'b0;
      cap_pend  <= 1'b0;
      gate_open <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cap_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state <= ARMED;
            busy  <= 1'b1;
          end
        end
        ARMED: begin
          if (start_event) begin
            state     <= GATE;
            gate_open <= 1'b1;
            sr        <= load_all(probe_data);
            win_cnt   <= COUNT_W'(1);
          end
        end
        GATE: begin
          if (stop_event) begin
            cap_sig  <= sr;
            cap_cnt  <= win_cnt;
            cap_ovf  <= &win_cnt;
            cap_pend <= 1'b1;
            if (continuous && start_event) begin
              sr      <= load_all(probe_data);
              win_cnt <= COUNT_W'(1);
            end else if (continuous) begin
              state     <= ARMED;
              gate_open <= 1'b0;
            end else begin
              state     <= IDLE;
              gate_open <= 1'b0;
              busy      <= 1'b0;
            end
          end else if (probe_edge) begin
            sr <= shift_all(sr, probe_data);
            if (win_cnt != '1) begin
              win_cnt <= win_cnt + COUNT_W'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          gate_open <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Publish a captured window: results and the valid pulse change together.
  always_ff @(posedge clock) begin
    if (reset) begin
      signature  <= '0;
      count      <= '0;
      count_ovf  <= 1'b0;
      sig_stable <= 1'b0;
      sig_valid  <= 1'b0;
      have_prior <= 1'b0;
    end else begin
      sig_valid <= cap_pend;
      if (cap_pend) begin
        signature  <= cap_sig;
        count      <= cap_cnt;
        count_ovf  <= cap_ovf;
        sig_stable <= have_prior && (cap_sig == signature);
        have_prior <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sigan_multi.sv
// Randomised bench for sigan_multi: a window-level reference model predicts
// every published result, its cycle, and the gate/busy flags.
module tb_sigan_multi;
  localparam int          CH   = 4;
  localparam int          W    = 16;
  localparam int          CW   = 4;
  localparam logic [15:0] POLY = 16'h8940;

  typedef struct {
    logic [CH*W-1:0] sig;
    logic [CW-1:0]   cnt;
    logic            ovf;
    logic            stable;
    int              at;
  } res_t;

  logic clock = 1'b0, reset = 1'b1, arm = 1'b0, continuous = 1'b0;
  logic clk_pol = 1'b1, start_pol = 1'b1, stop_pol = 1'b1;
  logic probe_clk = 1'b0, probe_start = 1'b0, probe_stop = 1'b0;
  logic [CH-1:0]   probe_data = '0;
  logic [CH*W-1:0] signature;
  logic            sig_valid, sig_stable, gate_open, busy, count_ovf;
  logic [CW-1:0]   count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  res_t            exp_q[$];
  res_t            mon_e;
  int              m_state;   // 0 idle, 1 armed, 2 gate
  logic            m_hs, m_hp, m_prior;
  logic [CH-1:0]   win[$];
  logic [CH*W-1:0] m_prev;

  sigan_multi #(.CHANNELS(CH), .WIDTH(W), .TAPS(POLY), .COUNT_W(CW)) dut (
    .clock(clock), .reset(reset), .arm(arm), .continuous(continuous),
    .clk_pol(clk_pol), .start_pol(start_pol), .stop_pol(stop_pol),
    .probe_clk(probe_clk), .probe_start(probe_start), .probe_stop(probe_stop),
    .probe_data(probe_data), .signature(signature), .sig_valid(sig_valid),
    .sig_stable(sig_stable), .gate_open(gate_open), .busy(busy),
    .count(count), .count_ovf(count_ovf)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: every published result must match the next predicted window.
  always @(negedge clock) begin
    if (!reset && sig_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sig_valid cycle=%0d sig=%h count=%0d", cyc, signature, count);
      end else begin
        mon_e = exp_q.pop_front();
        if (signature !== mon_e.sig || count !== mon_e.cnt || count_ovf !== mon_e.ovf ||
            sig_stable !== mon_e.stable || cyc != mon_e.at) begin
          errors++;
          $display("FAIL window_result got sig=%h cnt=%0d ovf=%b stable=%b cyc=%0d expected sig=%h cnt=%0d ovf=%b stable=%b cyc=%0d",
                   signature, count, count_ovf, sig_stable, cyc,
                   mon_e.sig, mon_e.cnt, mon_e.ovf, mon_e.stable, mon_e.at);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Window result computed from scratch from the list of sampled data words.
  task automatic model_close();
    res_t e;
    int   s, n, mx;
    for (int ch = 0; ch < CH; ch++) begin
      s = 0;
      foreach (win[j]) begin
        s = ((s << 1) & 32'hFFFF) | (int'(win[j][ch]) ^ ($countones(s & int'(POLY)) % 2));
      end
      e.sig[ch*W +: W] = 16'(s);
    end
    n        = win.size();
    mx       = (1 << CW) - 1;
    e.cnt    = CW'((n >= mx) ? mx : n);
    e.ovf    = (n >= mx);
    e.stable = m_prior && (e.sig == m_prev);
    e.at     = cyc + 2;
    m_prev   = e.sig;
    m_prior  = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic model_edge(input logic [CH-1:0] d, input logic st, input logic sp);
    logic se, pe;
    se   = (st == start_pol) && (m_hs != start_pol);
    pe   = (sp == stop_pol) && (m_hp != stop_pol);
    m_hs = st;
    m_hp = sp;
    if (m_state == 1 && se) begin
      win.delete();
      win.push_back(d);
      m_state = 2;
    end else if (m_state == 2) begin
      if (pe) begin
        model_close();
        win.delete();
        if (continuous && se) win.push_back(d);
        else m_state = continuous ? 1 : 0;
      end else begin
        win.push_back(d);
      end
    end
  endtask

  // One probe clock: inactive phase with junk inputs, active edge, then a
  // random hold of the active level with changing data (no extra edges).
  task automatic probe_cycle(input logic [CH-1:0] d, input logic st, input logic sp);
    probe_clk   = ~clk_pol;
    probe_data  = CH'($urandom);
    probe_start = 1'($urandom);
    probe_stop  = 1'($urandom);
    step();
    probe_clk   = clk_pol;
    probe_data  = d;
    probe_start = st;
    probe_stop  = sp;
    model_edge(d, st, sp);
    step();
    checks++;
    if (gate_open !== (m_state == 2) || busy !== (m_state != 0)) begin
      errors++;
      $display("FAIL gate_busy got gate=%b busy=%b expected gate=%b busy=%b",
               gate_open, busy, (m_state == 2), (m_state != 0));
    end
    repeat ($urandom_range(0, 2)) begin
      probe_data = CH'($urandom);
      step();
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    if (m_state == 0) m_state = 1;
    step();
    arm = 1'b0;
    checks++;
    if (busy !== (m_state != 0)) begin
      errors++;
      $display("FAIL arm_busy got %b expected %b", busy, (m_state != 0));
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    arm       = 1'b0;
    probe_clk = ~clk_pol;
    step();
    step();
    reset   = 1'b0;
    m_state = 0;
    m_hs    = 1'b0;
    m_hp    = 1'b0;
    m_prior = 1'b0;
    m_prev  = '0;
    win.delete();
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d undelivered windows expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (signature !== '0 || count !== '0 || sig_valid !== 1'b0 || sig_stable !== 1'b0 ||
        count_ovf !== 1'b0 || gate_open !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got sig=%h cnt=%h v=%b s=%b o=%b g=%b b=%b expected all 0",
               signature, count, sig_valid, sig_stable, count_ovf, gate_open, busy);
    end
    do_reset();
  endtask

  task automatic test_basic();
    continuous = 1'b0;
    do_reset();
    probe_cycle(CH'($urandom), 1'b1, 1'b0);   // idle: ignored
    probe_cycle(CH'($urandom), 1'b0, 1'b1);
    do_arm();
    probe_cycle({2'($urandom), 2'b01}, 1'b1, 1'b0);
    repeat (3) probe_cycle({2'($urandom), 2'b00}, 1'b0, 1'b0);
    probe_cycle(CH'($urandom), 1'b0, 1'b1);
    drain("basic");
    checks++;
    if (signature[15:0] !== 16'h0008 || signature[31:16] !== 16'h0000 || count !== 4'd4 ||
        sig_stable !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_window got ch0=%h ch1=%h cnt=%0d stable=%b busy=%b expected 0008 0000 4 0 0",
               signature[15:0], signature[31:16], count, sig_stable, busy);
    end
  endtask

  task automatic test_continuous_repeat();
    logic [1:0] hi[4];
    continuous = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) hi[i] = 2'($urandom);
    do_arm();
    for (int r = 0; r < 2; r++) begin
      probe_cycle({hi[0], 2'b01}, 1'b1, 1'b0);
      for (int i = 1; i < 4; i++) probe_cycle({hi[i], 2'b00}, 1'b0, 1'b0);
      probe_cycle(CH'($urandom), 1'b0, 1'b1);
      probe_cycle(CH'($urandom), 1'b0, 1'b0);
    end
    drain("continuous");
    checks++;
    if (signature[15:0] !== 16'h0008 || signature[31:16] !== 16'h0000 || sig_stable !== 1'b1) begin
      errors++;
      $display("FAIL continuous_stable got ch0=%h ch1=%h stable=%b expected 0008 0000 1",
               signature[15:0], signature[31:16], sig_stable);
    end
  endtask

  task automatic test_back_to_back();
    int len;
    continuous = 1'b1;
    do_reset();
    do_arm();
    len = 0;
    for (int ev = 0; ev < 6; ev++) begin
      len = $urandom_range(2, 7);
      probe_cycle(CH'($urandom), 1'b1, 1'b1);
      repeat (len - 1) probe_cycle(CH'($urandom), 1'b0, 1'b0);
    end
    probe_cycle(CH'($urandom), 1'b1, 1'b1);
    drain("tied");
    checks++;
    if (count !== CW'(len) || gate_open !== 1'b1) begin
      errors++;
      $display("FAIL tied_count got cnt=%0d gate=%b expected cnt=%0d gate=1", count, gate_open, len);
    end
  endtask

  task automatic test_clk_pol();
    logic [CH-1:0]   d[6];
    logic [CH*W-1:0] sig_r[2];
    for (int i = 0; i < 6; i++) d[i] = CH'($urandom);
    continuous = 1'b0;
    for (int p = 0; p < 2; p++) begin
      clk_pol = (p == 0);
      do_reset();
      do_arm();
      probe_cycle(d[0], 1'b1, 1'b0);
      for (int i = 1; i < 6; i++) probe_cycle(d[i], 1'b0, 1'b0);
      probe_cycle(CH'($urandom), 1'b0, 1'b1);
      drain("clk_pol");
      sig_r[p] = signature;
    end
    checks++;
    if (sig_r[1] !== sig_r[0]) begin
      errors++;
      $display("FAIL clk_pol_match got falling=%h expected rising=%h", sig_r[1], sig_r[0]);
    end
    clk_pol = 1'b1;
  endtask

  task automatic test_overflow();
    continuous = 1'b1;
    do_reset();
    do_arm();
    probe_cycle(CH'($urandom), 1'b1, 1'b0);
    repeat (19) probe_cycle(CH'($urandom), 1'b0, 1'b0);
    probe_cycle(CH'($urandom), 1'b0, 1'b1);
    drain("ovf_long");
    checks++;
    if (count !== 4'hF || count_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_long got cnt=%h ovf=%b expected F 1", count, count_ovf);
    end
    probe_cycle(CH'($urandom), 1'b0, 1'b0);
    probe_cycle(CH'($urandom), 1'b1, 1'b0);
    repeat (2) probe_cycle(CH'($urandom), 1'b0, 1'b0);
    probe_cycle(CH'($urandom), 1'b0, 1'b1);
    drain("ovf_short");
    checks++;
    if (count !== 4'h3 || count_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_short got cnt=%h ovf=%b expected 3 0", count, count_ovf);
    end
  endtask

  task automatic test_reset_mid();
    continuous = 1'b1;
    do_reset();
    do_arm();
    probe_cycle(CH'($urandom), 1'b1, 1'b0);
    probe_cycle(4'hF, 1'b0, 1'b0);
    probe_cycle(CH'($urandom), 1'b0, 1'b1);
    drain("mid_first");
    probe_cycle(CH'($urandom), 1'b1, 1'b0);
    repeat (3) probe_cycle(CH'($urandom), 1'b0, 1'b0);
    do_reset();
    checks++;
    if (signature !== '0 || count !== '0 || gate_open !== 1'b0 || busy !== 1'b0 ||
        sig_stable !== 1'b0 || count_ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state got sig=%h cnt=%h g=%b b=%b expected all 0",
               signature, count, gate_open, busy);
    end
    probe_cycle(CH'($urandom), 1'b0, 1'b1);
    probe_cycle(CH'($urandom), 1'b1, 1'b0);
    drain("mid_after");
  endtask

  task automatic test_arm_busy();
    continuous = 1'b0;
    do_reset();
    do_arm();
    do_arm();
    probe_cycle(CH'($urandom), 1'b1, 1'b0);
    probe_cycle(CH'($urandom), 1'b0, 1'b0);
    do_arm();
    probe_cycle(CH'($urandom), 1'b0, 1'b0);
    probe_cycle(CH'($urandom), 1'b0, 1'b1);
    probe_cycle(CH'($urandom), 1'b1, 1'b0);
    probe_cycle(CH'($urandom), 1'b0, 1'b0);
    probe_cycle(CH'($urandom), 1'b0, 1'b1);
    drain("arm_busy");
    checks++;
    if (busy !== 1'b0 || count !== CW'(3)) begin
      errors++;
      $display("FAIL arm_busy_window got busy=%b cnt=%0d expected busy=0 cnt=3", busy, count);
    end
  endtask

  task automatic test_random();
    start_pol = 1'($urandom);
    stop_pol  = 1'($urandom);
    do_reset();
    for (int i = 0; i < 80; i++) begin
      continuous = ($urandom_range(0, 3) != 0);
      if (m_state == 0 && $urandom_range(0, 1) == 1) do_arm();
      probe_cycle(CH'($urandom), ($urandom_range(0, 2) == 0) ? start_pol : ~start_pol,
                  ($urandom_range(0, 2) == 0) ? stop_pol : ~stop_pol);
    end
    drain("random");
    start_pol = 1'b1;
    stop_pol  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_continuous_repeat();
    test_back_to_back();
    test_clk_pol();
    test_overflow();
    test_reset_mid();
    test_arm_busy();
    repeat (3) test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
